// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared lane-state encoding, datapath width and add/sub helper
package addsub_pkg;

   localparam int   XLEN   = 32;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      LANE_IDLE = 2'b00,
      LANE_RUN  = 2'b01,
      LANE_DONE = 2'b10
   } lane_state_t;

   function automatic logic [XLEN-1:0] addsub_calc(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic            sub);
      return (sub == OP_SUB) ? a - b : a + b;
   endfunction

endpackage

// File: rtl/addsub_lane.sv
// rtl/addsub_lane.sv - one fixed-latency add/sub lane: IDLE -> RUN -> DONE, result held until drained
module addsub_lane
   import addsub_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic [XLEN-1:0]  op1,
   input  logic [XLEN-1:0]  op2,
   input  logic             sub,
   input  logic [TAG_W-1:0] tag,
   input  logic             src,
   input  logic             drain,
   output logic             idle,
   output logic             done,
   output logic [XLEN-1:0]  res,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_src
);

   lane_state_t     state;
   logic [2:0]      cnt;
   logic [XLEN-1:0] a_q;
   logic [XLEN-1:0] b_q;
   logic            sub_q;

   assign idle = (state == LANE_IDLE);
   assign done = (state == LANE_DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= LANE_IDLE;
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         res     <= '0;
         res_tag <= '0;
         res_src <= 1'b0;
      end else if (flush) begin
         state <= LANE_IDLE;
      end else begin
         case (state)
            LANE_IDLE: begin
               if (start) begin
                  a_q     <= op1;
                  b_q     <= op2;
                  sub_q   <= sub;
                  res_tag <= tag;
                  res_src <= src;
                  // A single-cycle lane has no RUN phase; the result is ready on the next cycle.
                  if (LAT == 1) begin
                     res   <= addsub_calc(op1, op2, sub);
                     state <= LANE_DONE;
                  end else begin
                     cnt   <= 3'(LAT - 1);
                     state <= LANE_RUN;
                  end
               end
            end
            LANE_RUN: begin
               if (cnt == 3'd1) begin
                  res   <= addsub_calc(a_q, b_q, sub_q);
                  state <= LANE_DONE;
               end
               cnt <= cnt - 3'd1;
            end
            LANE_DONE: begin
               if (drain) begin
                  state <= LANE_IDLE;
               end
            end
            default: state <= LANE_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/addsub_sched.sv
// rtl/addsub_sched.sv - shares two add/sub lanes between two issue slots, returns results in issue order
module addsub_sched
   import addsub_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [XLEN-1:0]  req0_op1,
   input  logic [XLEN-1:0]  req0_op2,
   input  logic             req0_sub,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [XLEN-1:0]  req1_op1,
   input  logic [XLEN-1:0]  req1_op2,
   input  logic             req1_sub,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XLEN-1:0]  rsp_res,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_src,
   output logic [1:0]       lane_busy
);

   logic [1:0]       idle;
   logic [1:0]       done;
   logic [1:0]       start;
   logic [1:0]       lsrc;
   logic [1:0]       drain;
   logic [1:0]       grant;
   logic [XLEN-1:0]  lane_res [2];
   logic [TAG_W-1:0] lane_tag [2];
   logic [1:0]       lane_src;
   logic             rr;
   logic             rr_nxt;
   logic             old_lane;
   logic             old_nxt;
   logic             sel;
   logic             free_lane;
   logic             win;
   logic             any_valid;

   // Grants look only at registered lane state, so a lane drained this cycle is not reused until next.
   always_comb begin
      grant     = 2'b00;
      start     = 2'b00;
      lsrc      = 2'b00;
      rr_nxt    = rr;
      old_nxt   = old_lane;
      free_lane = idle[0] ? 1'b0 : 1'b1;
      any_valid = req0_valid | req1_valid;
      win       = (req0_valid & req1_valid) ? rr : req1_valid;
      if (rst && !flush) begin
         if (&idle) begin
            grant = {req1_valid, req0_valid};
            if (req0_valid && req1_valid) begin
               start   = 2'b11;
               lsrc    = 2'b10;
               old_nxt = 1'b0;
            end else if (any_valid) begin
               start   = 2'b01;
               lsrc[0] = req1_valid;
               old_nxt = 1'b0;
            end
         end else if ((|idle) && any_valid) begin
            grant[win]       = 1'b1;
            start[free_lane] = 1'b1;
            lsrc[free_lane]  = win;
            rr_nxt           = ~win;
            old_nxt          = ~free_lane;
         end
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr       <= 1'b0;
         old_lane <= 1'b0;
      end else begin
         rr       <= rr_nxt;
         old_lane <= old_nxt;
      end
   end

   for (genvar l = 0; l < 2; l++) begin : g_lane
      assign drain[l] = rsp_valid & rsp_ready & ~flush & (sel == 1'(l));

      addsub_lane #(
         .LAT   (LAT),
         .TAG_W (TAG_W)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .start   (start[l]),
         .op1     (lsrc[l] ? req1_op1 : req0_op1),
         .op2     (lsrc[l] ? req1_op2 : req0_op2),
         .sub     (lsrc[l] ? req1_sub : req0_sub),
         .tag     (lsrc[l] ? req1_tag : req0_tag),
         .src     (lsrc[l]),
         .drain   (drain[l]),
         .idle    (idle[l]),
         .done    (done[l]),
         .res     (lane_res[l]),
         .res_tag (lane_tag[l]),
         .res_src (lane_src[l])
      );
   end

   assign sel       = (&done) ? old_lane : done[1];
   assign rsp_valid = |done;
   assign rsp_res   = lane_res[sel];
   assign rsp_tag   = lane_tag[sel];
   assign rsp_src   = lane_src[sel];
   assign lane_busy = ~idle;

endmodule
